if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage of the RV32I core, sitting between the PC register and decode. Each cycle it consumes the current PC and issues word fetches to instruction memory over a valid/ready request channel. It buffers in-order responses with their PCs in a small ring buffer and hands {pc, instruction} to decode over a valid/ready channel. It also generates PC_Next for the PC register (hold, +4, or redirect target), and discards in-flight fetches on a branch/jump redirect.

## Interface
- DEPTH, 2, ring-buffer entries and maximum outstanding fetches; power of two, 2..8
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- PC  in  32  current PC from the PC register
- PC_Next  out  32  next PC to the PC register
- redirect  in  1  taken branch/jump from execute; flushes fetch
- redirect_target  in  32  new PC; bits [1:0] forced to 0
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address (= PC)
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after accept, no backpressure
- imem_rsp_data  in  32  fetched instruction word
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts instruction
- instr_data  out  32  instruction word at buffer head
- instr_pc  out  32  PC of instr_data

## Operation
- Ring buffer of DEPTH entries {pc, data, filled}, with head/tail pointers, alloc_count (0..DEPTH) and drop_count (0..DEPTH).
- Issue: imem_req_valid = rst & ~redirect & (alloc_count < DEPTH) & (drop_count == 0). imem_req_addr = PC.
- Accept (req_valid & req_ready): allocate tail entry with pc = PC and filled = 0.
- PC_Next priority:
  - redirect: {redirect_target[31:2], 2'b00}
  - else accept: PC + 4, modulo 2^32
  - else: PC (hold)
- Response with drop_count > 0: decrement drop_count; data discarded.
- Response with drop_count == 0: write data into the oldest unfilled entry and set filled.
- instr_valid = head entry allocated & filled. instr_data and instr_pc come from registered head state.
- Pop: instr_valid & instr_ready frees the head entry.
- Redirect (priority over everything):
  - Clear all entries: alloc_count = 0, head = tail.
  - drop_count_next = drop_count + (allocated-but-unfilled count) − imem_rsp_valid.
  - Any pop in the same cycle is irrelevant, since all entries are discarded.
- Invariant: drop_count > 0 implies alloc_count == 0, because issue is blocked while dropping.
- A response arriving with no outstanding request is a protocol error by memory; behaviour is undefined.

## Timing
- Reset (rst low, asynchronous): imem_req_valid = 0, instr_valid = 0, PC_Next = 0, imem_req_addr = PC, instr_data = 0, instr_pc = 0. All pointers and counters are 0.
- Request to PC_Next is combinational; the PC register updates on the same edge as the accept.
- Response to instr_valid: 1 cycle (filled on the edge, visible after). No same-cycle bypass.
- Steady state with 1-cycle memory and instr_ready = 1: one instruction per cycle. DEPTH = 2 covers the loop.
- Redirect cycle:
  - No request is issued.
  - The first fetch from the target is issued next cycle, provided drop_count == 0.
  - Otherwise it is issued after the final discarded response.
- Simultaneous fill and pop of different entries: both take effect. alloc_count changes by −1 only on pop; filling does not change it.
- Full (alloc_count == DEPTH): req_valid = 0, PC_Next = PC.

## Test plan
- Reset: hold rst low with PC = 0 → req_valid = 0, instr_valid = 0, PC_Next = 0. Release with req_ready = 1 → imem_req_addr = 0, PC_Next = 4.
- Streaming: 1-cycle memory returning data = addr ^ 32'hA5A5_0000, instr_ready = 1 → decode receives pc 0, 4, 8, 12 on consecutive cycles with matching data.
- Backpressure: instr_ready = 0, DEPTH = 2 → exactly two requests (0, 4), then req_valid = 0 and PC_Next = PC = 8 holds. Raising instr_ready drains 0 then 4, and fetching resumes at 8.
- Memory stall: req_ready = 0 for 3 cycles at PC = 0x20 → PC_Next = 0x20 each cycle, and no entry is allocated.
- Redirect flush: two requests in flight (0x40, 0x44), redirect to 0x103 → PC_Next = 0x100, the next two responses are discarded, and the first instr_pc delivered is 0x100. Repeat with a response arriving in the redirect cycle → only one further response is discarded.
- Wrap: PC = 0xFFFF_FFFC accepted → PC_Next = 0x0000_0000. Asserting rst mid-stream → outputs return to reset values immediately.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I fetch stage issuing word fetches, buffering in-order
// responses with their PCs and presenting {pc, instruction} to decode.
module if_fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    output logic [31:0] PC_Next,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [AW-1:0]    r_head, r_tail, r_fptr;
    logic [CW-1:0]    r_alloc, r_pend, r_drop;
    logic             w_accept, w_pop, w_fill, w_unused;
    assign imem_req_valid = rst & ~redirect & (r_alloc < FULL) & (r_drop == '0);
    assign imem_req_addr  = PC;
    assign w_accept       = imem_req_valid & imem_req_ready;
    assign w_pop          = instr_valid & instr_ready;
    assign w_fill         = imem_rsp_valid & (r_drop == '0);
    assign instr_valid    = (r_alloc != '0) & r_filled[r_head];
    assign instr_data     = r_data[r_head];
    assign instr_pc       = r_pc[r_head];
    assign w_unused       = ^redirect_target[1:0];
    always_comb
        PC_Next = !rst ? '0 : redirect ? {redirect_target[31:2], 2'b00} : w_accept ? PC + 32'd4 : PC;
    // r_fptr tracks the oldest allocated-but-unfilled entry; responses are in order
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_fptr   <= '0;
            r_alloc  <= '0;
            r_pend   <= '0;
            r_drop   <= '0;
            r_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (redirect) begin
            r_head   <= r_tail;
            r_fptr   <= r_tail;
            r_alloc  <= '0;
            r_pend   <= '0;
            r_filled <= '0;
            r_drop   <= r_drop + r_pend - CW'(imem_rsp_valid);
        end else begin
            if (w_accept) begin
                r_pc[r_tail]     <= PC;
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + AW'(1);
            end
            if (w_fill) begin
                r_data[r_fptr]   <= imem_rsp_data;
                r_filled[r_fptr] <= 1'b1;
                r_fptr           <= r_fptr + AW'(1);
            end
            if (w_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + AW'(1);
            end
            r_alloc <= r_alloc + CW'(w_accept) - CW'(w_pop);
            r_pend  <= r_pend + CW'(w_accept) - CW'(w_fill);
            if (imem_rsp_valid && r_drop != '0)
                r_drop <= r_drop - CW'(1);
        end
    end
endmodule
